// File: rtl/hazard_stall_unit.sv
// Pipeline hazard stall/flush controller: load-use, branch, jump and data-memory wait.
// Control outputs are combinational from state and inputs; state and perf counters are registered.
module hazard_stall_unit #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned COUNT_W           = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        IR_IF_ID_out,
    input  logic [31:0]        IR_ID_EX_out,
    input  logic               MemRead_ID_EX_out,
    input  logic               Jump_ID,
    input  logic               BranchTaken_EX,
    input  logic               mem_busy,
    output logic               PCWrite,
    output logic               IF_ID_Write,
    output logic               IF_ID_Flush,
    output logic               ID_EX_Write,
    output logic               ID_EX_Flush,
    output logic               EX_MEM_Write,
    output logic [COUNT_W-1:0] stall_cycles,
    output logic [COUNT_W-1:0] flush_cycles
);

    localparam int unsigned REM_W = 3;
    localparam logic [REM_W-1:0] LU_EXTRA = REM_W'(LOAD_STALL_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t             state, nextState;
    state_t             resumeState, nextResume;
    state_t             evalState;
    logic [REM_W-1:0]   remaining, nextRemaining;

    logic pcWr, ifIdWr, ifIdFl, idExWr, idExFl, exMemWr;
    logic loadUse, usesRt;
    logic [4:0] ldDst, idRs, idRt;
    logic [5:0] idOp;
    logic unusedIrBits;

    assign ldDst = IR_ID_EX_out[20:16];
    assign idRs  = IR_IF_ID_out[25:21];
    assign idRt  = IR_IF_ID_out[20:16];
    assign idOp  = IR_IF_ID_out[31:26];
    assign unusedIrBits = ^{IR_ID_EX_out[31:21], IR_ID_EX_out[15:0], IR_IF_ID_out[15:0]};

    // rt is a source only for R-type, beq, bne and sw
    assign usesRt  = (idOp == 6'h00) || (idOp == 6'h04) || (idOp == 6'h05) || (idOp == 6'h2b);
    assign loadUse = MemRead_ID_EX_out && (ldDst != 5'd0) &&
                     ((ldDst == idRs) || (usesRt && (ldDst == idRt)));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            resumeState <= RUN;
            remaining   <= '0;
        end else begin
            state       <= nextState;
            resumeState <= nextResume;
            remaining   <= nextRemaining;
        end
    end

    // Next-state and control decode
    always_comb begin
        pcWr          = 1'b1;
        ifIdWr        = 1'b1;
        ifIdFl        = 1'b0;
        idExWr        = 1'b1;
        idExFl        = 1'b0;
        exMemWr       = 1'b1;
        nextState     = state;
        nextResume    = resumeState;
        nextRemaining = remaining;
        evalState     = state;

        // Leaving MEM_WAIT acts as the saved state within the same cycle
        if (state == MEM_WAIT) begin
            evalState = resumeState;
        end

        if (state == MEM_WAIT && mem_busy) begin
            pcWr    = 1'b0;
            ifIdWr  = 1'b0;
            idExWr  = 1'b0;
            exMemWr = 1'b0;
        end else begin
            case (evalState)
                LU_STALL: begin
                    if (mem_busy) begin
                        pcWr       = 1'b0;
                        ifIdWr     = 1'b0;
                        idExWr     = 1'b0;
                        exMemWr    = 1'b0;
                        nextResume = LU_STALL;
                        nextState  = MEM_WAIT;
                    end else if (BranchTaken_EX) begin
                        ifIdFl        = 1'b1;
                        idExFl        = 1'b1;
                        nextRemaining = '0;
                        nextState     = RUN;
                    end else begin
                        pcWr   = 1'b0;
                        ifIdWr = 1'b0;
                        idExFl = 1'b1;
                        if (remaining <= REM_W'(1)) begin
                            nextRemaining = '0;
                            nextState     = RUN;
                        end else begin
                            nextRemaining = remaining - REM_W'(1);
                            nextState     = LU_STALL;
                        end
                    end
                end
                default: begin
                    nextState = RUN;
                    if (mem_busy) begin
                        pcWr       = 1'b0;
                        ifIdWr     = 1'b0;
                        idExWr     = 1'b0;
                        exMemWr    = 1'b0;
                        nextResume = RUN;
                        nextState  = MEM_WAIT;
                    end else if (BranchTaken_EX) begin
                        ifIdFl = 1'b1;
                        idExFl = 1'b1;
                    end else if (loadUse) begin
                        pcWr   = 1'b0;
                        ifIdWr = 1'b0;
                        idExFl = 1'b1;
                        if (LU_EXTRA != '0) begin
                            nextRemaining = LU_EXTRA;
                            nextState     = LU_STALL;
                        end
                    end else if (Jump_ID) begin
                        ifIdFl = 1'b1;
                    end
                end
            endcase
        end
    end

    // Reset forces every enable and flush low while it is held
    assign PCWrite      = reset & pcWr;
    assign IF_ID_Write  = reset & ifIdWr;
    assign IF_ID_Flush  = reset & ifIdFl;
    assign ID_EX_Write  = reset & idExWr;
    assign ID_EX_Flush  = reset & idExFl;
    assign EX_MEM_Write = reset & exMemWr;

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (!pcWr && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + COUNT_W'(1);
            end
            if (ifIdFl && (flush_cycles != '1)) begin
                flush_cycles <= flush_cycles + COUNT_W'(1);
            end
        end
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Producer-side companion to the EX-stage forwarding logic. It detects hazards that forwarding cannot cover: load-use, taken branch, jump, and data-memory wait. For each it drives the pipeline write enables and flushes (PC, IF/ID, ID/EX, EX/MEM). A small FSM sequences multi-cycle load-use penalties and memory-wait freezes, and saturating counters record stall and flush cycles.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
COUNT_W, 16, width of the stall and flush performance counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low (0 = reset)
IR_IF_ID_out  input  32  instruction in ID
IR_ID_EX_out  input  32  instruction in EX
MemRead_ID_EX_out  input  1  EX instruction is a load
Jump_ID  input  1  ID instruction is j/jal/jr/jalr
BranchTaken_EX  input  1  branch in EX resolved taken
mem_busy  input  1  data memory not ready this cycle
PCWrite  output  1  PC update enable
IF_ID_Write  output  1  IF/ID register enable
IF_ID_Flush  output  1  IF/ID cleared to nop
ID_EX_Write  output  1  ID/EX register enable
ID_EX_Flush  output  1  ID/EX cleared to bubble
EX_MEM_Write  output  1  EX/MEM register enable
stall_cycles  output  COUNT_W  cycles with PCWrite=0, saturating
flush_cycles  output  COUNT_W  cycles with IF_ID_Flush=1, saturating

Behaviour:
- Reset (reset=0, async): state=RUN, remaining=0, counters=0. While reset is held, all Write outputs are 0 and all Flush outputs are 0.
- Control outputs are combinational from state and inputs, with no added latency. State and counters update on the clk rising edge.
- Load-use detect (lu): MemRead_ID_EX_out=1, ldst=IR_ID_EX_out[20:16]!=0, and ldst matches IF/ID rs (IR_IF_ID_out[25:21]), or ldst matches IF/ID rt (IR_IF_ID_out[20:16]) when the IF/ID opcode [31:26] is 0x00, 0x04, 0x05 or 0x2b.
- Default (no event): all Write=1, all Flush=0.
- FSM states: RUN, LU_STALL, MEM_WAIT. Per-cycle priority: mem_busy > BranchTaken_EX > load-use > Jump_ID.
- RUN:
  - mem_busy=1: all four Write=0, no flush. Save resume=RUN. Go to MEM_WAIT.
  - Else BranchTaken_EX=1: IF_ID_Flush=1, ID_EX_Flush=1, Writes=1. Stay in RUN.
  - Else lu=1: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. If LOAD_STALL_CYCLES>1, set remaining=LOAD_STALL_CYCLES-1 and go to LU_STALL.
  - Else Jump_ID=1: IF_ID_Flush=1 only.
- LU_STALL:
  - mem_busy=1: freeze as in RUN, save resume=LU_STALL, hold remaining, go to MEM_WAIT.
  - Else BranchTaken_EX=1: branch flush as in RUN, clear remaining, go to RUN.
  - Else: stall outputs as for lu. Decrement remaining; go to RUN when it reaches 0.
  - Jump_ID is ignored while in LU_STALL.
- MEM_WAIT:
  - All four Write=0, all Flush=0, while mem_busy=1.
  - On the first cycle with mem_busy=0, evaluate as the resume state in that same cycle, then continue from it.
- Counters: stall_cycles increments on each cycle with PCWrite=0; flush_cycles on each cycle with IF_ID_Flush=1. Both stick at all-ones (no wrap).
- Reset mid-LU_STALL or mid-MEM_WAIT: immediately returns to RUN, remaining=0, counters=0.
- Never flag a hazard for register $0.

Test Plan:
- lw $8,0($1) in EX; add $9,$8,$2 in ID; LOAD_STALL_CYCLES=1 → exactly 1 cycle with PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; then all defaults; stall_cycles=1.
- lw $0 in EX with $0 source in ID; separately lw $8 with sw's rt=$8 (0x2b) and addi's rt=$8 (0x08) in ID → no stall for $0 or addi; 1-cycle stall for sw.
- LOAD_STALL_CYCLES=3, load-use → 3 consecutive stall cycles, then RUN; pulse mem_busy=1 for 2 cycles after the first stall cycle → freeze 2 cycles, then the remaining 2 stall cycles; stall_cycles=5.
- BranchTaken_EX=1 together with lu=1 and Jump_ID=1 → IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1; flush_cycles=1.
- reset=0 asserted asynchronously mid-LU_STALL (between clock edges) → outputs 0 immediately; after release, state=RUN, counters=0, defaults on the next cycle.
- COUNT_W=4, mem_busy held 20 cycles → stall_cycles=15 and stays at 15.
